// File: rtl/dflow_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dflow_pkg : shared widths and replay FSM encoding for dflow blocks |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package dflow_pkg;

  localparam int DFLOW_REC_WIDTH  = 144;
  localparam int DFLOW_ADDR_WIDTH = 19;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_CAL = 3'd1,
    ISSUE    = 3'd2,
    DRAIN    = 3'd3,
    DONE     = 3'd4
  } replay_state_t;

endpackage
`default_nettype wire

// File: rtl/dflow_replay_reader_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dflow_replay_reader_if : QDR read port + outqueue FIFO write port  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface dflow_replay_reader_if
  import dflow_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = DFLOW_ADDR_WIDTH,
  parameter int MEM_DATA_WIDTH = DFLOW_REC_WIDTH
);
  logic                      app_rd_cmd;
  logic [MEM_ADDR_WIDTH-1:0] app_rd_addr;
  logic                      app_rd_valid;
  logic [MEM_DATA_WIDTH-1:0] app_rd_data;
  logic                      fifo_wr_en;
  logic [MEM_DATA_WIDTH-1:0] fifo_data;
  logic                      fifo_nearly_full;

  modport master (
    output app_rd_cmd, app_rd_addr, fifo_wr_en, fifo_data,
    input  app_rd_valid, app_rd_data, fifo_nearly_full
  );

  modport slave (
    input  app_rd_cmd, app_rd_addr, fifo_wr_en, fifo_data,
    output app_rd_valid, app_rd_data, fifo_nearly_full
  );
endinterface
`default_nettype wire

// File: rtl/dflow_rd_credit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dflow_rd_credit : in-flight QDR read counter with issue permission |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module dflow_rd_credit #(
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic issue,
  input  logic ret,
  output logic can_issue,
  output logic drained_next
);
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_next;

  // A return with nothing outstanding is illegal upstream; hold at zero.
  always_comb begin
    w_next = r_count;
    if (issue && !ret)
      w_next = r_count + CW'(1);
    else if (ret && !issue && (r_count != '0))
      w_next = r_count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) r_count <= '0;
    else     r_count <= w_next;
  end

  assign can_issue    = (r_count < CW'(MAX_OUTSTANDING));
  assign drained_next = (w_next == '0);
endmodule
`default_nettype wire

// File: rtl/dflow_replay_reader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dflow_replay_reader : replays QDR records [low,high) N passes      |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module dflow_replay_reader
  import dflow_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH     = DFLOW_ADDR_WIDTH,
  parameter int MEM_DATA_WIDTH     = DFLOW_REC_WIDTH,
  parameter int REPLAY_COUNT_WIDTH = 32,
  parameter int MAX_OUTSTANDING    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sw_rst,
  input  logic                          cal_done,
  input  logic                          start_replay,
  input  logic                          abort_replay,
  input  logic [REPLAY_COUNT_WIDTH-1:0] replay_count,
  input  logic [MEM_ADDR_WIDTH-1:0]     addr_low,
  input  logic [MEM_ADDR_WIDTH-1:0]     addr_high,
  dflow_replay_reader_if.master         bus,
  output logic                          replay_busy,
  output logic                          replay_done,
  output logic [REPLAY_COUNT_WIDTH-1:0] passes_done
);
  replay_state_t                 r_state;
  logic                          r_start_q;
  logic [MEM_ADDR_WIDTH-1:0]     r_low, r_high, r_addr, r_cmd_addr;
  logic [REPLAY_COUNT_WIDTH-1:0] r_count;
  logic                          r_cmd, r_wr_en;
  logic [MEM_DATA_WIDTH-1:0]     r_wr_data;

  logic w_rst, w_start_edge, w_window, w_issue, w_last, w_finish;
  logic w_can_issue, w_drained_next, w_fwd;
  logic [REPLAY_COUNT_WIDTH-1:0] w_pass_next;

  assign w_rst        = rst | sw_rst;
  assign w_start_edge = start_replay & ~r_start_q;
  // Issuing starts on the WAIT_CAL exit edge so the first read lands two cycles after start.
  assign w_window     = (r_state == ISSUE) ||
                        ((r_state == WAIT_CAL) && cal_done && (r_high != r_low));
  assign w_issue      = w_window && !bus.fifo_nearly_full && w_can_issue && !abort_replay;
  assign w_last       = (r_addr == r_high - MEM_ADDR_WIDTH'(1));
  assign w_pass_next  = passes_done + REPLAY_COUNT_WIDTH'(1);
  assign w_finish     = w_issue && w_last && (r_count != '0) && (w_pass_next == r_count);
  assign w_fwd        = bus.app_rd_valid && (r_state != IDLE);

  dflow_rd_credit #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_credit (
    .clk          (clk),
    .rst          (w_rst),
    .issue        (w_issue),
    .ret          (bus.app_rd_valid),
    .can_issue    (w_can_issue),
    .drained_next (w_drained_next)
  );

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_state     <= IDLE;
      r_start_q   <= 1'b0;
      r_low       <= '0;
      r_high      <= '0;
      r_addr      <= '0;
      r_count     <= '0;
      r_cmd       <= 1'b0;
      r_cmd_addr  <= '0;
      r_wr_en     <= 1'b0;
      r_wr_data   <= '0;
      replay_busy <= 1'b0;
      replay_done <= 1'b0;
      passes_done <= '0;
    end else begin
      r_start_q   <= start_replay;
      r_cmd       <= w_issue;
      r_wr_en     <= w_fwd;
      replay_done <= 1'b0;
      if (w_fwd) r_wr_data <= bus.app_rd_data;

      if (w_issue) begin
        r_cmd_addr <= r_addr;
        if (w_last) begin
          r_addr      <= r_low;
          passes_done <= w_pass_next;
        end else begin
          r_addr <= r_addr + MEM_ADDR_WIDTH'(1);
        end
      end

      case (r_state)
        IDLE: if (w_start_edge) begin
          r_low       <= addr_low;
          r_high      <= addr_high;
          r_addr      <= addr_low;
          r_count     <= replay_count;
          passes_done <= '0;
          replay_busy <= 1'b1;
          r_state     <= WAIT_CAL;
        end
        WAIT_CAL: if (cal_done) begin
          if (r_high == r_low) begin
            replay_done <= 1'b1;
            r_state     <= DONE;
          end else if (abort_replay || w_finish) begin
            r_state <= DRAIN;
          end else begin
            r_state <= ISSUE;
          end
        end
        ISSUE: if (abort_replay || w_finish) r_state <= DRAIN;
        DRAIN: if (w_drained_next) begin
          replay_done <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          replay_busy <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.app_rd_cmd  = r_cmd;
  assign bus.app_rd_addr = r_cmd_addr;
  assign bus.fifo_wr_en  = r_wr_en;
  assign bus.fifo_data   = r_wr_data;
endmodule
`default_nettype wire
